// File: rtl/spike_event_logger.sv
// Spike event logger: timestamps rising edges of the LIF spike line into a
// first-word-fall-through FIFO, with a saturating spike counter and sticky overflow.
module spike_event_logger #(
  parameter int TS_WIDTH  = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   spike,
  input  logic                   clear,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [TS_WIDTH-1:0]    ev_ts,
  output logic [$clog2(DEPTH):0] ev_level,
  output logic [CNT_WIDTH-1:0]   spike_count,
  output logic                   overflow
);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [TS_WIDTH-1:0] ts_cnt;
  logic                spike_q;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [TS_WIDTH-1:0] mem [DEPTH];

  logic spike_edge;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign spike_edge = spike & ~spike_q;
  assign full       = (ev_level == FULL_LEVEL);
  assign ev_valid   = (ev_level != '0);
  assign ev_ts      = ev_valid ? mem[rd_ptr] : '0;

  // A pop frees the slot the same cycle, so an edge at full is still accepted.
  assign pop  = ev_valid & ev_ready & ~clear;
  assign push = spike_edge & (~full | pop) & ~clear;
  assign drop = spike_edge & full & ~pop & ~clear;

  // NOTE: the storage array has no reset; ev_level gates ev_ts so stale
  // contents are never visible, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ts_cnt;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, e.g. the event word is the pre-increment ts_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt      <= '0;
      spike_q     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ev_level    <= '0;
      spike_count <= '0;
      overflow    <= 1'b0;
    end else begin
      // spike_q keeps sampling through clear so a held spike is not re-logged.
      spike_q <= spike;
      if (clear) begin
        ts_cnt      <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        ev_level    <= '0;
        spike_count <= '0;
        overflow    <= 1'b0;
      end else begin
        ts_cnt <= ts_cnt + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      ev_level <= ev_level + 1'b1;
        else if (pop && !push) ev_level <= ev_level - 1'b1;
        if (drop) overflow <= 1'b1;
        if (spike_edge && (spike_count != '1)) spike_count <= spike_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spike_event_logger.sv
// Self-checking bench for spike_event_logger: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_spike_event_logger;
  localparam int TS_WIDTH  = 8;
  localparam int DEPTH     = 4;
  localparam int CNT_WIDTH = 8;
  localparam int TS_MOD    = 1 << TS_WIDTH;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   spike;
  logic                   clear;
  logic                   ev_ready;
  logic                   ev_valid;
  logic [TS_WIDTH-1:0]    ev_ts;
  logic [$clog2(DEPTH):0] ev_level;
  logic [CNT_WIDTH-1:0]   spike_count;
  logic                   overflow;

  spike_event_logger #(.TS_WIDTH(TS_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .spike(spike), .clear(clear),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ts(ev_ts), .ev_level(ev_level),
    .spike_count(spike_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of logged timestamps plus scalar bookkeeping.
  int q[$];
  int m_ts;
  bit m_prev;
  int m_cnt;
  bit m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts = 0; m_prev = 1'b0; m_cnt = 0; m_ovf = 1'b0;
  endtask

  task automatic model_clock();
    bit ev;
    if (clear) begin
      q.delete();
      m_ts = 0; m_cnt = 0; m_ovf = 1'b0;
    end else begin
      ev = spike && !m_prev;
      if (q.size() > 0 && ev_ready) void'(q.pop_front());
      if (ev) begin
        if (q.size() < DEPTH) q.push_back(m_ts);
        else m_ovf = 1'b1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
      m_ts = (m_ts + 1) % TS_MOD;
    end
    m_prev = spike;
  endtask

  task automatic compare_model();
    check("ev_valid", 32'(ev_valid), 32'(q.size() != 0));
    check("ev_ts", 32'(ev_ts), (q.size() != 0) ? q[0] : 0);
    check("ev_level", 32'(ev_level), q.size());
    check("spike_count", 32'(spike_count), m_cnt);
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: model and DUT see the same inputs at the edge; compare 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    compare_model();
  endtask

  task automatic pulse();
    spike = 1'b1; step();
    spike = 1'b0; step();
  endtask

  task automatic idle_to(input int target);
    spike = 1'b0; clear = 1'b0;
    for (int i = 0; i < TS_MOD && m_ts != target; i++) step();
  endtask

  task automatic drain_one(input string name, input int exp_ts);
    check(name, 32'(ev_ts), exp_ts);
    ev_ready = 1'b1; step(); ev_ready = 1'b0;
  endtask

  // Called just after an edge: reset must clear outputs before the next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    check("rst ev_valid", 32'(ev_valid), 0);
    check("rst ev_ts", 32'(ev_ts), 0);
    check("rst ev_level", 32'(ev_level), 0);
    check("rst spike_count", 32'(spike_count), 0);
    check("rst overflow", 32'(overflow), 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic spike;
    int   valid;
    int   ts;
    int   level;
    int   count;
  } vec_t;

  vec_t vecs[9];

  initial begin
    rst_n = 1'b1; spike = 1'b0; clear = 1'b0; ev_ready = 1'b0;
    model_reset();
    #6;
    do_reset();

    // Single 3-cycle pulse starting at ts 5: row k is the edge where ts_cnt = k.
    for (int k = 0; k < 9; k++) begin
      vecs[k].spike = (k >= 5 && k <= 7);
      vecs[k].valid = (k >= 5) ? 1 : 0;
      vecs[k].ts    = (k >= 5) ? 5 : 0;
      vecs[k].level = (k >= 5) ? 1 : 0;
      vecs[k].count = (k >= 5) ? 1 : 0;
    end
    for (int k = 0; k < 9; k++) begin
      spike = vecs[k].spike;
      step();
      check($sformatf("vec%0d ev_valid", k), 32'(ev_valid), vecs[k].valid);
      check($sformatf("vec%0d ev_ts", k), 32'(ev_ts), vecs[k].ts);
      check($sformatf("vec%0d ev_level", k), 32'(ev_level), vecs[k].level);
      check($sformatf("vec%0d spike_count", k), 32'(spike_count), vecs[k].count);
    end
    spike = 1'b0;

    // Fill and overflow.
    do_reset();
    idle_to(10);
    for (int i = 0; i < 5; i++) pulse();
    check("fill level", 32'(ev_level), 4);
    check("fill overflow", 32'(overflow), 1);
    check("fill count", 32'(spike_count), 5);
    drain_one("drain0", 10);
    drain_one("drain1", 12);
    drain_one("drain2", 14);
    drain_one("drain3", 16);
    check("drained valid", 32'(ev_valid), 0);

    // Push and pop together at full.
    do_reset();
    idle_to(30);
    for (int i = 0; i < 4; i++) pulse();
    idle_to(40);
    spike = 1'b1; ev_ready = 1'b1; step();
    spike = 1'b0; ev_ready = 1'b0;
    check("pp level", 32'(ev_level), 4);
    check("pp overflow", 32'(overflow), 0);
    check("pp head", 32'(ev_ts), 32);
    drain_one("pp drain0", 32);
    drain_one("pp drain1", 34);
    drain_one("pp drain2", 36);
    drain_one("pp tail", 40);

    // Timestamp wrap.
    idle_to(254);
    pulse();
    spike = 1'b1; step(); spike = 1'b0;
    drain_one("wrap0", 254);
    drain_one("wrap1", 0);

    // Counter saturation, then clear coincident with an edge.
    ev_ready = 1'b1;
    for (int i = 0; i < 300; i++) pulse();
    check("sat count", 32'(spike_count), CNT_MAX);
    ev_ready = 1'b0;
    pulse(); pulse();
    spike = 1'b1; clear = 1'b1; step(); clear = 1'b0;
    check("clr count", 32'(spike_count), 0);
    check("clr level", 32'(ev_level), 0);
    check("clr overflow", 32'(overflow), 0);
    check("clr valid", 32'(ev_valid), 0);
    step();
    check("held across clr", 32'(spike_count), 0);
    spike = 1'b0; step();

    // Randomized traffic; low ready rate first to provoke overflow.
    for (int i = 0; i < 600; i++) begin
      spike    = 1'($urandom_range(0, 1));
      ev_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clear    = ($urandom_range(0, 63) == 0);
      step();
    end
    spike = 1'b0; clear = 1'b0; ev_ready = 1'b0;

    // Async reset mid-stream with three events buffered.
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < 3; i++) pulse();
    check("pre-rst level", 32'(ev_level), 3);
    do_reset();

    // Spike already high at the first edge after reset counts as an edge.
    spike = 1'b1; step();
    check("post-rst edge count", 32'(spike_count), 1);
    check("post-rst edge ts", 32'(ev_ts), 0);
    spike = 1'b0; step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
